// File: rtl/fetch_sequencer.sv
// fetch_sequencer: drives the registered-read instruction memory, tags each
// returned word with its PC and a valid flag, and handles stalls and
// redirects (JMP/branch, CALL, RET). Optional return-address stack is
// enabled by defining FETCH_RAS_EN; the default build has no RAS storage.
module fetch_sequencer #(
  parameter int unsigned           ADDR_W    = 16,
  parameter int unsigned           INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC  = 16'h0000,
  parameter int unsigned           MEM_WORDS = 64,
  parameter logic [INSTR_W-1:0]    NOP_WORD  = 16'hF000,
  parameter int unsigned           RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [1:0]         redirect_kind,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic [ADDR_W-1:0]  redirect_link,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic               fault,
  output logic [2:0]         ras_depth
);

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_fault;

  logic                w_is_ret;
  logic                w_is_call;
  logic [ADDR_W-1:0]   w_ret_target;
  logic                w_ret_fault;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_addr_oob;

  // Kind 11 is reserved and falls through to plain JMP handling.
  assign w_is_ret  = redirect_valid && (redirect_kind == 2'b10);
  assign w_is_call = redirect_valid && (redirect_kind == 2'b01);

`ifdef FETCH_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_ras_empty;
  logic              w_push;
  logic              w_pop;

  assign w_ras_empty = (r_cnt == '0);
  assign w_push      = (r_state == ST_RUN) && w_is_call;
  assign w_pop       = (r_state == ST_RUN) && w_is_ret && !w_ras_empty;
  // An empty-stack RET holds the address; the fetch faults on this edge anyway.
  assign w_ret_target = w_ras_empty ? r_pc : r_ras[r_sp - PTR_W'(1)];
  assign w_ret_fault  = w_ras_empty;
  assign ras_depth    = 3'(r_cnt);

  // Circular return stack: r_sp is the next write slot, a full push
  // overwrites the oldest entry while the occupancy count saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[r_sp] <= redirect_link;
      r_sp        <= r_sp + PTR_W'(1);
      if (r_cnt != CNT_W'(RAS_DEPTH)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else if (w_pop) begin
      r_sp  <= r_sp - PTR_W'(1);
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
`else
  logic w_unused_link;

  assign w_unused_link = ^redirect_link;
  assign w_ret_target  = redirect_target;
  assign w_ret_fault   = 1'b0;
  assign ras_depth     = '0;
`endif

  // Next fetch address: reset > fault freeze > redirect > stall > sequential.
  always_comb begin
    w_next_addr = r_pc;
    if (reset) begin
      w_next_addr = RESET_PC;
    end else if (r_state == ST_FAULT) begin
      w_next_addr = r_pc;
    end else if (redirect_valid) begin
      w_next_addr = w_is_ret ? w_ret_target : redirect_target;
    end else if (stall) begin
      w_next_addr = r_pc;
    end else begin
      w_next_addr = r_pc + ADDR_W'(1);
    end
  end

  assign w_addr_oob = ({1'b0, w_next_addr} >= MEM_LIMIT);
  assign imem_addr  = w_next_addr;

  // RUN/FAULT state machine; pc_q tracks the address whose data imem returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_pc <= w_next_addr;
      if (w_addr_oob || (w_is_ret && w_ret_fault)) begin
        r_state <= ST_FAULT;
        r_fault <= 1'b1;
      end
    end
  end

  assign if_valid = (r_state == ST_RUN) && !redirect_valid;
  assign if_instr = if_valid ? imem_instr : NOP_WORD;
  assign if_pc    = r_pc;
  assign fault    = r_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random
// stimulus, all checked against a behavioural model (PC, fault flag and a
// queue-based return stack) evaluated once per cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_kind;
  logic [15:0] redirect_target;
  logic [15:0] redirect_link;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        fault;
  logic [2:0]  ras_depth;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] mem [64];

  // Reference state
  logic [15:0] m_pc    = '0;
  logic        m_fault = 1'b0;
  logic        m_known = 1'b0;
  logic [15:0] m_ras [$];

  fetch_sequencer #(
    .ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000),
    .MEM_WORDS(64), .NOP_WORD(16'hF000), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
    .redirect_target(redirect_target), .redirect_link(redirect_link),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
    .fault(fault), .ras_depth(ras_depth)
  );

  always #5 clk = ~clk;

  // Instruction memory with a one-cycle registered read.
  always @(posedge clk) begin
    imem_instr <= (imem_addr < 16'd64) ? mem[imem_addr[5:0]] : 16'hBAD0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model.
  task automatic cycle(input logic rst, input logic st, input logic rv,
                       input logic [1:0] kind, input logic [15:0] tgt,
                       input logic [15:0] lnk);
    logic [15:0] n_pc;
    logic        n_fault;
    logic        n_known;
    logic        exp_valid;
    reset = rst; stall = st; redirect_valid = rv;
    redirect_kind = kind; redirect_target = tgt; redirect_link = lnk;
    n_pc = m_pc; n_fault = m_fault; n_known = m_known;
    if (rst) begin
      n_pc = 16'h0000; n_fault = 1'b0; n_known = 1'b1;
      m_ras.delete();
    end else if (!m_fault) begin
      if (rv) begin
        if (kind == 2'b10) begin
`ifdef FETCH_RAS_EN
          if (m_ras.size() == 0) begin
            n_fault = 1'b1; n_known = 1'b0;
          end else begin
            n_pc = m_ras.pop_back();
          end
`else
          n_pc = tgt;
`endif
        end else begin
          n_pc = tgt;
`ifdef FETCH_RAS_EN
          if (kind == 2'b01) begin
            m_ras.push_back(lnk);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
`endif
        end
      end else if (!st) begin
        n_pc = m_pc + 16'd1;
      end
      if (n_known && n_pc >= 16'd64) n_fault = 1'b1;
    end
    @(negedge clk);
    if (rst) begin
      check("imem_addr_rst", 32'(imem_addr), 32'h0);
    end else begin
      exp_valid = !m_fault && !rv;
      check("if_valid", 32'(if_valid), 32'(exp_valid));
      check("if_instr", 32'(if_instr), exp_valid ? 32'(mem[m_pc[5:0]]) : 32'hF000);
      check("fault", 32'(fault), 32'(m_fault));
      if (m_known) check("if_pc", 32'(if_pc), 32'(m_pc));
      if (n_known) check("imem_addr", 32'(imem_addr), 32'(n_pc));
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_fault = n_fault; m_known = n_known;
`ifdef FETCH_RAS_EN
    check("ras_depth", 32'(ras_depth), 32'(m_ras.size()));
`else
    check("ras_depth", 32'(ras_depth), 32'h0);
`endif
  endtask

  initial begin
    logic rr, rs, rv;
    logic [1:0] rk;
    logic [15:0] rt;
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0764; mem[1] = 16'h1031; mem[2] = 16'h3241; mem[3] = 16'h1002;

    // T1: reset two cycles; first word visible right after reset
    cycle(1, 0, 0, 2'b00, 0, 0);
    cycle(1, 0, 0, 2'b00, 0, 0);
    check("t1_pc0", 32'(if_pc), 32'h0);
    check("t1_instr0", 32'(if_instr), 32'h0764);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    // T2: stall three cycles at pc 2
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    // Back to pc 2, then T3 CALL (with a stall that must be ignored)
    cycle(0, 0, 1, 2'b00, 16'd2, 0);
    cycle(0, 1, 1, 2'b01, 16'd3, 16'd2);
    // T4: RET, then a second RET
    cycle(0, 0, 1, 2'b10, 16'd5, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 1, 2'b10, 16'd5, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    // T5: out-of-range JMP faults; inputs ignored until reset
    cycle(1, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 1, 2'b00, 16'd70, 0);
    check("t5_fault", 32'(fault), 32'h1);
    cycle(0, 1, 0, 2'b00, 0, 0);
    cycle(0, 0, 1, 2'b01, 16'd4, 16'd9);
    cycle(0, 0, 0, 2'b00, 0, 0);
    cycle(1, 0, 1, 2'b00, 16'd9, 0);
    check("t5_pc_after_reset", 32'(if_pc), 32'h0);
    // T6: five CALLs then four RETs
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 2'b01, 16'(20 + i), 16'(10 + i));
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 2'b10, 16'd5, 0);
    cycle(0, 0, 0, 2'b00, 0, 0);
    // Boundary: sequential run from 62 crosses the end of memory
    cycle(1, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 1, 2'b00, 16'd62, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 2'b00, 0, 0);
    // Reserved kind behaves like JMP
    cycle(1, 0, 0, 2'b00, 0, 0);
    cycle(0, 0, 1, 2'b11, 16'd40, 16'd7);
    cycle(0, 0, 0, 2'b00, 0, 0);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      rr = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) < 2);
      rs = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 3) == 0);
      rk = 2'($urandom_range(0, 3));
      rt = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(64, 200))
                                        : 16'($urandom_range(0, 63));
      cycle(rr, rs, rv, rk, rt, 16'($urandom_range(0, 63)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
